// File: rtl/load_align_if.sv
`default_nettype none
// ============================================================================
// Module   : load_align_if
// Brief    : Request, memory-read and result signals of the load alignment unit.
// Revision : 1.0
// ============================================================================
interface load_align_if;
    logic        start;
    logic [2:0]  load_type;
    logic [1:0]  byte_offset;
    logic [31:0] rt_old;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;
    logic        mem_read;
    logic [31:0] result;
    logic        result_valid;
    logic        busy;
    logic        addr_error;

    modport slave (
        input  start, load_type, byte_offset, rt_old, mem_readdata, mem_waitrequest,
        output mem_read, result, result_valid, busy, addr_error
    );

    modport master (
        output start, load_type, byte_offset, rt_old, mem_readdata, mem_waitrequest,
        input  mem_read, result, result_valid, busy, addr_error
    );
endinterface
`default_nettype wire

// File: rtl/load_align_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_align_unit
// Brief    : Reads one memory word and aligns/extends it for LB/LBU/LH/LHU/LW/LWL/LWR.
// Revision : 1.0
// ============================================================================
module load_align_unit (
    input  logic        clk,
    input  logic        reset,
    load_align_if.slave bus
);
    localparam logic [2:0] c_LT_LB  = 3'b000;
    localparam logic [2:0] c_LT_LBU = 3'b001;
    localparam logic [2:0] c_LT_LH  = 3'b010;
    localparam logic [2:0] c_LT_LHU = 3'b011;
    localparam logic [2:0] c_LT_LW  = 3'b100;
    localparam logic [2:0] c_LT_LWL = 3'b101;
    localparam logic [2:0] c_LT_LWR = 3'b110;
    localparam logic [2:0] c_LT_BAD = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_RESP = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  type_q, type_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] rt_q, rt_d;
    logic [31:0] data_q, data_d;
    logic [31:0] result_q, result_d;
    logic        mem_read_q, result_valid_q, addr_error_q;

    logic        w_reject;
    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_aligned;

    // Requests that must never reach memory: invalid type or misaligned halfword/word.
    always_comb begin
        w_reject = 1'b0;
        case (bus.load_type)
            c_LT_BAD:           w_reject = 1'b1;
            c_LT_LH, c_LT_LHU:  w_reject = bus.byte_offset[0];
            c_LT_LW:            w_reject = (bus.byte_offset != 2'b00);
            default:            w_reject = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        off_d   = off_q;
        rt_d    = rt_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    type_d  = bus.load_type;
                    off_d   = bus.byte_offset;
                    rt_d    = bus.rt_old;
                    state_d = w_reject ? S_ERR : S_READ;
                end
            end
            S_READ: begin
                if (!bus.mem_waitrequest) begin
                    data_d  = bus.mem_readdata;
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Little-endian lane selection from the captured word.
    always_comb begin
        w_shifted = data_q >> {off_q, 3'b000};
        w_byte    = w_shifted[7:0];
        w_half    = off_q[1] ? data_q[31:16] : data_q[15:0];
        w_aligned = 32'h0;
        case (type_q)
            c_LT_LB:  w_aligned = {{24{w_byte[7]}}, w_byte};
            c_LT_LBU: w_aligned = {24'h0, w_byte};
            c_LT_LH:  w_aligned = {{16{w_half[15]}}, w_half};
            c_LT_LHU: w_aligned = {16'h0, w_half};
            c_LT_LW:  w_aligned = data_q;
            c_LT_LWL: begin
                case (off_q)
                    2'd0:    w_aligned = {data_q[7:0],  rt_q[23:0]};
                    2'd1:    w_aligned = {data_q[15:0], rt_q[15:0]};
                    2'd2:    w_aligned = {data_q[23:0], rt_q[7:0]};
                    default: w_aligned = data_q;
                endcase
            end
            c_LT_LWR: begin
                case (off_q)
                    2'd0:    w_aligned = data_q;
                    2'd1:    w_aligned = {rt_q[31:24], data_q[31:8]};
                    2'd2:    w_aligned = {rt_q[31:16], data_q[31:16]};
                    default: w_aligned = {rt_q[31:8],  data_q[31:24]};
                endcase
            end
            default:  w_aligned = 32'h0;
        endcase
        result_d = (state_q == S_RESP) ? w_aligned : result_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            type_q         <= 3'b000;
            off_q          <= 2'b00;
            rt_q           <= 32'h0;
            data_q         <= 32'h0;
            result_q       <= 32'h0;
            mem_read_q     <= 1'b0;
            result_valid_q <= 1'b0;
            addr_error_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            type_q         <= type_d;
            off_q          <= off_d;
            rt_q           <= rt_d;
            data_q         <= data_d;
            result_q       <= result_d;
            mem_read_q     <= (state_d == S_READ);
            result_valid_q <= (state_q == S_RESP);
            addr_error_q   <= (state_d == S_ERR);
        end
    end

    assign bus.mem_read     = mem_read_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.addr_error   = addr_error_q;
    assign bus.busy         = (state_q != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_load_align_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_align_unit
// Brief    : Directed self-checking bench for load_align_unit.
// Revision : 1.0
// ============================================================================
module tb_load_align_unit;
    localparam logic [2:0] c_LB  = 3'b000;
    localparam logic [2:0] c_LBU = 3'b001;
    localparam logic [2:0] c_LH  = 3'b010;
    localparam logic [2:0] c_LHU = 3'b011;
    localparam logic [2:0] c_LW  = 3'b100;
    localparam logic [2:0] c_LWL = 3'b101;
    localparam logic [2:0] c_LWR = 3'b110;
    localparam logic [2:0] c_BAD = 3'b111;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    load_align_if bus ();

    load_align_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request and records what the DUT did over the following cycles.
    task automatic do_load(input logic [2:0] lt, input logic [1:0] off, input logic [31:0] rt,
                           input logic [31:0] rd, input int waits,
                           output logic [31:0] res, output int rd_cycles, output int vld_cnt,
                           output int vld_lat, output int err_cnt);
        res = 32'h0; rd_cycles = 0; vld_cnt = 0; vld_lat = -1; err_cnt = 0;
        bus.start = 1'b1; bus.load_type = lt; bus.byte_offset = off; bus.rt_old = rt;
        bus.mem_readdata = rd; bus.mem_waitrequest = (waits > 0);
        for (int c = 0; c < waits + 8; c++) begin
            tick();
            bus.start = 1'b0;
            if (bus.mem_read) begin
                rd_cycles++;
                bus.mem_waitrequest = (rd_cycles <= waits);
            end
            if (bus.result_valid) begin
                vld_cnt++;
                vld_lat = c;
                res = bus.result;
            end
            if (bus.addr_error) err_cnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0; bus.load_type = 3'b000; bus.byte_offset = 2'b00;
        bus.rt_old = 32'h0; bus.mem_readdata = 32'h0; bus.mem_waitrequest = 1'b0;
        repeat (3) tick();
        vectors++; if (bus.mem_read !== 1'b0) begin miscompares++; $display("FAIL reset_mem_read: got %0b want 0", bus.mem_read); end
        vectors++; if (bus.result !== 32'h0) begin miscompares++; $display("FAIL reset_result: got %h want 00000000", bus.result); end
        vectors++; if (bus.result_valid !== 1'b0) begin miscompares++; $display("FAIL reset_result_valid: got %0b want 0", bus.result_valid); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
        vectors++; if (bus.addr_error !== 1'b0) begin miscompares++; $display("FAIL reset_addr_error: got %0b want 0", bus.addr_error); end
        reset = 1'b0;
        tick();
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL idle_no_start_busy: got %0b want 0", bus.busy); end
    endtask

    task automatic test_lb();
        logic [31:0] res; int rdc, vc, vl, ec;
        do_load(c_LB, 2'd3, 32'h0, 32'h80FF7F01, 0, res, rdc, vc, vl, ec);
        vectors++; if (res !== 32'hFFFFFF80) begin miscompares++; $display("FAIL lb_result: got %h want FFFFFF80", res); end
        vectors++; if (rdc !== 1) begin miscompares++; $display("FAIL lb_mem_read_cycles: got %0d want 1", rdc); end
        vectors++; if (vl !== 2) begin miscompares++; $display("FAIL lb_latency: got %0d want 2", vl); end
        vectors++; if (vc !== 1) begin miscompares++; $display("FAIL lb_valid_pulses: got %0d want 1", vc); end
    endtask

    task automatic test_lhu_wait();
        logic [31:0] res; int rdc, vc, vl, ec;
        do_load(c_LHU, 2'd2, 32'h0, 32'hBEEF1234, 3, res, rdc, vc, vl, ec);
        vectors++; if (res !== 32'h0000BEEF) begin miscompares++; $display("FAIL lhu_result: got %h want 0000BEEF", res); end
        vectors++; if (rdc !== 4) begin miscompares++; $display("FAIL lhu_mem_read_cycles: got %0d want 4", rdc); end
        vectors++; if (vc !== 1) begin miscompares++; $display("FAIL lhu_valid_pulses: got %0d want 1", vc); end
        vectors++; if (vl !== 5) begin miscompares++; $display("FAIL lhu_latency: got %0d want 5", vl); end
    endtask

    task automatic test_lwl_lwr();
        logic [31:0] res; int rdc, vc, vl, ec;
        do_load(c_LWL, 2'd1, 32'hAABBCCDD, 32'h44332211, 0, res, rdc, vc, vl, ec);
        vectors++; if (res !== 32'h2211CCDD) begin miscompares++; $display("FAIL lwl_result: got %h want 2211CCDD", res); end
        do_load(c_LWR, 2'd1, 32'hAABBCCDD, 32'h44332211, 0, res, rdc, vc, vl, ec);
        vectors++; if (res !== 32'hAA443322) begin miscompares++; $display("FAIL lwr_result: got %h want AA443322", res); end
    endtask

    task automatic test_vectors();
        logic [2:0]  lts [15] = '{c_LBU, c_LB, c_LB, c_LBU, c_LH, c_LH, c_LHU, c_LH, c_LW,
                                  c_LWL, c_LWL, c_LWL, c_LWR, c_LWR, c_LWR};
        logic [1:0]  offs[15] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0,
                                  2'd0, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3};
        logic [31:0] rds [15] = '{32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01,
                                  32'h80FF7F01, 32'h80FF7F01, 32'hBEEF1234, 32'hBEEF1234,
                                  32'hBEEF1234, 32'h44332211, 32'h44332211, 32'h44332211,
                                  32'h44332211, 32'h44332211, 32'h44332211};
        logic [31:0] exps[15] = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'h00000080,
                                  32'h00007F01, 32'hFFFF80FF, 32'h00001234, 32'hFFFFBEEF,
                                  32'hBEEF1234, 32'h11BBCCDD, 32'h332211DD, 32'h44332211,
                                  32'h44332211, 32'hAABB4433, 32'hAABBCC44};
        logic [31:0] res; int rdc, vc, vl, ec;
        for (int i = 0; i < 15; i++) begin
            do_load(lts[i], offs[i], 32'hAABBCCDD, rds[i], 0, res, rdc, vc, vl, ec);
            vectors++;
            if (res !== exps[i] || vc !== 1) begin
                miscompares++;
                $display("FAIL vector_%0d type=%0d off=%0d: got %h (%0d pulses) want %h (1 pulse)",
                         i, lts[i], offs[i], res, vc, exps[i]);
            end
        end
    endtask

    task automatic test_addr_error();
        logic [2:0]  lts [4] = '{c_LW, c_LH, c_LHU, c_BAD};
        logic [1:0]  offs[4] = '{2'd2, 2'd1, 2'd3, 2'd0};
        logic [31:0] res; int rdc, vc, vl, ec;
        do_load(c_LW, 2'd0, 32'h0, 32'hCAFEF00D, 0, res, rdc, vc, vl, ec);
        vectors++; if (res !== 32'hCAFEF00D) begin miscompares++; $display("FAIL err_setup_lw: got %h want CAFEF00D", res); end
        for (int i = 0; i < 4; i++) begin
            do_load(lts[i], offs[i], 32'h0, 32'h11111111, 0, res, rdc, vc, vl, ec);
            vectors++; if (ec !== 1) begin miscompares++; $display("FAIL err_%0d_pulses: got %0d want 1", i, ec); end
            vectors++; if (rdc !== 0) begin miscompares++; $display("FAIL err_%0d_mem_read: got %0d want 0", i, rdc); end
            vectors++; if (vc !== 0) begin miscompares++; $display("FAIL err_%0d_valid: got %0d want 0", i, vc); end
            vectors++; if (bus.result !== 32'hCAFEF00D) begin miscompares++; $display("FAIL err_%0d_result_held: got %h want CAFEF00D", i, bus.result); end
        end
        do_load(c_LW, 2'd0, 32'h0, 32'h0BADBEEF, 0, res, rdc, vc, vl, ec);
        vectors++; if (res !== 32'h0BADBEEF || vl !== 2) begin miscompares++; $display("FAIL err_recover: got %h lat %0d want 0BADBEEF lat 2", res, vl); end
    endtask

    task automatic test_back_to_back();
        int busy_cnt = 0;
        int vld_total = 0;
        bus.start = 1'b1; bus.load_type = c_LB; bus.byte_offset = 2'd3; bus.rt_old = 32'h0;
        bus.mem_readdata = 32'h80FF7F01; bus.mem_waitrequest = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.result_valid) vld_total++;
            if (c <= 3 && bus.busy) busy_cnt++;
            if (c == 2) bus.mem_waitrequest = 1'b0;
            if (c == 4) begin
                vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_gap_busy: got %0b want 0", bus.busy); end
                vectors++; if (bus.result_valid !== 1'b1 || bus.result !== 32'hFFFFFF80) begin
                    miscompares++; $display("FAIL b2b_first_result: got %h valid %0b want FFFFFF80 valid 1", bus.result, bus.result_valid); end
            end
            if (c == 5) begin
                vectors++; if (bus.mem_read !== 1'b1) begin miscompares++; $display("FAIL b2b_second_start: got mem_read %0b want 1", bus.mem_read); end
                bus.start = 1'b0;
                bus.mem_readdata = 32'h7F000000;
            end
            if (c == 7) begin
                vectors++; if (bus.result_valid !== 1'b1 || bus.result !== 32'h0000007F) begin
                    miscompares++; $display("FAIL b2b_second_result: got %h valid %0b want 0000007F valid 1", bus.result, bus.result_valid); end
            end
        end
        vectors++; if (busy_cnt !== 4) begin miscompares++; $display("FAIL b2b_busy_cycles: got %0d want 4", busy_cnt); end
        vectors++; if (vld_total !== 2) begin miscompares++; $display("FAIL b2b_valid_pulses: got %0d want 2", vld_total); end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] res; int rdc, vc, vl, ec;
        bus.start = 1'b1; bus.load_type = c_LW; bus.byte_offset = 2'd0;
        bus.mem_readdata = 32'h12345678; bus.mem_waitrequest = 1'b1;
        tick();
        bus.start = 1'b0;
        vectors++; if (bus.mem_read !== 1'b1) begin miscompares++; $display("FAIL rst_pre_mem_read: got %0b want 1", bus.mem_read); end
        #1 reset = 1'b1;
        #1;
        vectors++; if (bus.mem_read !== 1'b0) begin miscompares++; $display("FAIL rst_async_mem_read: got %0b want 0", bus.mem_read); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_async_busy: got %0b want 0", bus.busy); end
        bus.mem_waitrequest = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        vectors++; if (bus.result !== 32'h0) begin miscompares++; $display("FAIL rst_result_cleared: got %h want 00000000", bus.result); end
        do_load(c_LBU, 2'd1, 32'h0, 32'h80FF7F01, 0, res, rdc, vc, vl, ec);
        vectors++; if (vc !== 1) begin miscompares++; $display("FAIL rst_no_stale_valid: got %0d pulses want 1", vc); end
        vectors++; if (res !== 32'h0000007F || vl !== 2) begin miscompares++; $display("FAIL rst_new_lbu: got %h lat %0d want 0000007F lat 2", res, vl); end
    endtask

    initial begin
        test_reset();
        test_lb();
        test_lhu_wait();
        test_lwl_lwr();
        test_vectors();
        test_addr_error();
        test_back_to_back();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/load_align_unit.md
LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

Interface
REQ-001 Parameters: none; all widths are fixed at 32-bit data and a 2-bit byte offset.
REQ-002 clk  input  1  system clock; all state SHALL change on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request one load-alignment operation; sampled only in IDLE.
REQ-005 load_type  input  3  operation: 000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 LWL, 110 LWR, 111 invalid.
REQ-006 byte_offset  input  2  address bits [1:0], taken from the stored ALU-out LSB register.
REQ-007 rt_old  input  32  current rt value, used only for the LWL/LWR merge.
REQ-008 mem_readdata  input  32  word read from memory.
REQ-009 mem_waitrequest  input  1  memory stall; readdata is valid in a cycle where mem_read=1 and waitrequest=0.
REQ-010 mem_read  output  1  memory read strobe.
REQ-011 result  output  32  aligned and extended load result.
REQ-012 result_valid  output  1  one-cycle pulse marking result as valid.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 addr_error  output  1  one-cycle pulse on a misaligned access or invalid load_type.

Function
REQ-015 FSM states SHALL be IDLE, READ, RESP and ERR; encoding is free.
REQ-016 In IDLE with start=1, the block SHALL latch load_type, byte_offset and rt_old.
REQ-017 Transition from IDLE after start=1:
  - to ERR if load_type=111;
  - to ERR if LH/LHU with byte_offset[0]=1;
  - to ERR if LW with byte_offset!=00;
  - to READ otherwise.
REQ-018 ERR SHALL assert addr_error for exactly one cycle, SHALL NOT assert mem_read, and SHALL return to IDLE.
REQ-019 In READ, mem_read SHALL be 1; the state SHALL hold while mem_waitrequest=1.
REQ-020 In READ with mem_waitrequest=0, mem_readdata SHALL be captured at that edge and the FSM SHALL go to RESP.
REQ-021 RESP SHALL assert result_valid for one cycle and then return to IDLE.
REQ-022 Minimum latency: start sampled at edge N; result_valid high in the cycle after edge N+2, when the first READ cycle has no wait state.
REQ-023 start asserted while busy=1 SHALL be ignored; no queuing.
REQ-024 Byte order SHALL be little-endian: byte k = readdata[8k+7:8k].
REQ-025 Results by load type:
  - LB: sign-extend byte k.
  - LBU: zero-extend byte k.
  - LH: sign-extend the halfword at bits [16h+15:16h], h = byte_offset[1].
  - LHU: zero-extend the same halfword.
  - LW: the word unchanged.
REQ-026 LWL, k = byte_offset: result = (readdata << 8*(3-k)) with the low (3-k) bytes taken from rt_old.
REQ-027 LWR, k = byte_offset: result = (readdata >> 8k) with the high k bytes taken from rt_old.
REQ-028 result SHALL hold its last value outside RESP; it SHALL NOT change in ERR.
REQ-029 mem_read, result_valid and addr_error SHALL be registered outputs, glitch-free.

Reset
REQ-030 While reset=1, the block SHALL asynchronously force: state=IDLE, mem_read=0, result=0, result_valid=0, busy=0, addr_error=0.
REQ-031 Reset asserted in READ SHALL drop mem_read in the same cycle; the captured data SHALL be discarded and no result_valid SHALL follow.
REQ-032 The first start SHALL be accepted at the first rising edge after reset deasserts.

Verification
REQ-033 LB, offset 11, readdata 0x80FF7F01, no wait -> mem_read for 1 cycle; result 0xFFFFFF80 with result_valid 2 cycles after start.
REQ-034 LHU, offset 10, readdata 0xBEEF1234, waitrequest held 3 cycles -> mem_read held 4 cycles; result 0x0000BEEF; exactly one result_valid pulse.
REQ-035 LWL, offset 01, readdata 0x44332211, rt_old 0xAABBCCDD -> result 0x2211CCDD; LWR with the same values -> result 0xAA443322.
REQ-036 LW, offset 10 -> addr_error pulses for 1 cycle; mem_read stays 0; result unchanged; next start accepted normally.
REQ-037 Reset asserted mid-READ, then a new LBU start -> mem_read drops immediately; no stale result_valid; the new operation completes correctly.
REQ-038 start held high through a whole operation -> the second operation begins only from IDLE; busy=1 for the whole first transaction.
